// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and size helpers for the BRAM port arbiter.
package bram_arb_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } arb_state_e;

   // Address width of a 16 Kbit RAMB16_RIGEL-style port for a given data width
   function automatic int unsigned addr_w(input int unsigned bits);
      return 32'(14 - $clog2(bits));
   endfunction

   function automatic int unsigned depth(input int unsigned bits);
      return 32'(16384 / bits);
   endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx
);

   int unsigned cand;
   logic        found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = 32'(ptr) + i;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!found && req[IDX_W'(cand)]) begin
            found               = 1'b1;
            grant[IDX_W'(cand)] = 1'b1;
            idx                 = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one BRAM port among NREQ requesters, with zero-fill after reset.
// Define BRAM_ARB_RSP_REG_EN to add an output register on rsp_* (read latency 2 instead of 1).
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned BITS   = 8,
   parameter int unsigned ADDR_W = addr_w(BITS),
   parameter int unsigned DEPTH  = depth(BITS)
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ-1:0]          req_we,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*BITS-1:0]     req_wdata,
   output logic                     rsp_valid,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [BITS-1:0]          rsp_data,
   output logic                     init_done,
   output logic                     ram_en,
   output logic                     ram_we,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [BITS-1:0]          ram_din,
   input  logic [BITS-1:0]          ram_dout
);

   localparam int unsigned IDX_W = $clog2(NREQ);

   arb_state_e         state_q, state_d;
   logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               init_done_q, init_done_d;
   logic               rd_vld_q, rd_vld_d;
   logic [IDX_W-1:0]   rd_id_q, rd_id_d;

   logic               run_c;
   logic [NREQ-1:0]    arb_req_c;
   logic [NREQ-1:0]    grant_c;
   logic [IDX_W-1:0]   gidx_c;
   logic               granted_c;

   // Requests are only visible to the arbiter once zero-fill has finished
   assign run_c     = (state_q == RUN) && !reset;
   assign arb_req_c = req_valid & {NREQ{run_c}};

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req   (arb_req_c),
      .ptr   (rr_ptr_q),
      .grant (grant_c),
      .idx   (gidx_c)
   );

   assign granted_c = |grant_c;
   assign req_ready = grant_c;
   assign init_done = init_done_q;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      rr_ptr_d   = rr_ptr_q;
      rd_vld_d   = 1'b0;
      rd_id_d    = rd_id_q;
      ram_en     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_din    = '0;

      if (state_q == CLEAR) begin
         if (!reset) begin
            ram_en     = 1'b1;
            ram_we     = 1'b1;
            ram_addr   = clr_addr_q;
            clr_addr_d = ADDR_W'(clr_addr_q + 1'b1);
            if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = RUN;
            end
         end
      end else if (granted_c) begin
         ram_en   = 1'b1;
         ram_we   = req_we[gidx_c];
         ram_addr = req_addr[32'(gidx_c)*ADDR_W +: ADDR_W];
         ram_din  = req_wdata[32'(gidx_c)*BITS +: BITS];
         rr_ptr_d = (gidx_c == IDX_W'(NREQ - 1)) ? '0 : IDX_W'(gidx_c + 1'b1);
         rd_vld_d = !req_we[gidx_c];
         rd_id_d  = gidx_c;
      end

      init_done_d = (state_d == RUN);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= CLEAR;
         clr_addr_q  <= '0;
         rr_ptr_q    <= '0;
         init_done_q <= 1'b0;
         rd_vld_q    <= 1'b0;
         rd_id_q     <= '0;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         rr_ptr_q    <= rr_ptr_d;
         init_done_q <= init_done_d;
         rd_vld_q    <= rd_vld_d;
         rd_id_q     <= rd_id_d;
      end
   end

`ifdef BRAM_ARB_RSP_REG_EN
   logic               rsp_valid_q, rsp_valid_d;
   logic [IDX_W-1:0]   rsp_id_q, rsp_id_d;
   logic [BITS-1:0]    rsp_data_q, rsp_data_d;

   // Second tag stage captures the BRAM output alongside its requester index
   always_comb begin
      rsp_valid_d = rd_vld_q;
      rsp_id_d    = rd_vld_q ? rd_id_q : '0;
      rsp_data_d  = rd_vld_q ? ram_dout : '0;
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
`else
   // BRAM DOA is already registered, so the response is presented straight from it
   assign rsp_valid = rd_vld_q && !reset;
   assign rsp_id    = rd_vld_q ? rd_id_q : '0;
   assign rsp_data  = rd_vld_q ? ram_dout : '0;
`endif

endmodule
